// File: rtl/intr_pkg.sv
// intr_pkg -- shared definitions for the interrupt controller.
//   state_t        : request FSM encoding (IDLE / REQ)
//   prio_t         : result of the priority encoder (valid flag + index)
//   prio_enc()     : lowest-index-set-bit encoder over up to MAX_CH channels
//   VEC_BASE_DEF / VEC_STRIDE_DEF : default vector table placement
package intr_pkg;

    localparam int         MAX_CH         = 16;
    localparam int         IDX_W          = 4;
    localparam logic [9:0] VEC_BASE_DEF   = 10'h3C0;
    localparam int         VEC_STRIDE_DEF = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } prio_t;

    // Channel 0 is highest priority, so the lowest set bit wins. Scanning
    // from the top down lets the last hit (the lowest index) stick.
    function automatic prio_t prio_enc(input logic [MAX_CH-1:0] vec);
        prio_t r;
        r.valid = 1'b0;
        r.idx   = '0;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                r.valid = 1'b1;
                r.idx   = IDX_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/intr_timer.sv
// intr_timer -- periodic tick source for channel 0.
//   clk, reset     : clock, asynchronous active-low reset
//   timer_we       : write strobe for the reload value
//   timer_load     : reload value; 0 disables the timer
//   tick           : one-cycle pulse each time the count reaches 1
module intr_timer #(
    parameter int TIMER_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               timer_we,
    input  logic [TIMER_W-1:0] timer_load,
    output logic               tick
);

    logic [TIMER_W-1:0] reload;
    logic [TIMER_W-1:0] count;

    // The tick is asserted during the cycle the count sits at 1; the
    // controller samples it on the same edge that reloads the count, so the
    // period is exactly 'reload' cycles.
    assign tick = (reload != '0) && (count == TIMER_W'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reload <= '0;
            count  <= '0;
        end else if (timer_we) begin
            reload <= timer_load;
            count  <= timer_load;
        end else if (reload == '0) begin
            count  <= '0;
        end else if (count <= TIMER_W'(1)) begin
            // count==0 with a live reload cannot arise normally; treat it
            // like the terminal count so the timer never gets stuck.
            count  <= reload;
        end else begin
            count  <= count - TIMER_W'(1);
        end
    end

endmodule

// File: rtl/intr_ctrl.sv
// intr_ctrl -- prioritised, nesting interrupt controller.
//   clk, reset       : clock, asynchronous active-low reset
//   irq_in           : external sources (edge or level per EDGE_MASK)
//   mask_we/wdata    : mask register write (1 = channel enabled)
//   timer_we/load    : periodic timer reload (0 = off); ticks into channel 0
//   ack              : CPU took the request and jumped to vec_addr
//   done             : CPU returned from the innermost handler
//   irq_req          : request to the CPU (high exactly in REQ)
//   vec_addr         : VEC_BASE + index*VEC_STRIDE while requesting, else 0
//   pending          : pending bits
//   in_service       : in-service bits (one per nested handler level)
module intr_ctrl
    import intr_pkg::*;
#(
    parameter int                N_CH       = 4,
    parameter int                ADDR_W     = 10,
    parameter logic [ADDR_W-1:0] VEC_BASE   = ADDR_W'(VEC_BASE_DEF),
    parameter int                VEC_STRIDE = VEC_STRIDE_DEF,
    parameter logic [N_CH-1:0]   EDGE_MASK  = '1,
    parameter int                TIMER_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_CH-1:0]    irq_in,
    input  logic               mask_we,
    input  logic [N_CH-1:0]    mask_wdata,
    input  logic               timer_we,
    input  logic [TIMER_W-1:0] timer_load,
    input  logic               ack,
    input  logic               done,
    output logic               irq_req,
    output logic [ADDR_W-1:0]  vec_addr,
    output logic [N_CH-1:0]    pending,
    output logic [N_CH-1:0]    in_service
);

    state_t            state;
    logic [N_CH-1:0]   mask;
    logic [N_CH-1:0]   irq_prev;
    logic [N_CH-1:0]   cur_oh;      // one-hot of the latched channel

    logic              tick;
    logic [N_CH-1:0]   mask_next;
    logic [N_CH-1:0]   set_vec;
    logic [N_CH-1:0]   cand_oh;
    logic [N_CH-1:0]   done_clr;
    logic [N_CH-1:0]   ack_set;
    logic [N_CH-1:0]   pending_next;
    logic [N_CH-1:0]   in_service_next;
    logic [ADDR_W-1:0] vec_calc;
    prio_t             cand;
    prio_t             isv;
    logic              accept;
    logic              ack_take;
    logic              withdraw;

    intr_timer #(
        .TIMER_W (TIMER_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .timer_we   (timer_we),
        .timer_load (timer_load),
        .tick       (tick)
    );

    // Selection and withdrawal look at the mask value being written this
    // cycle, so masking the latched channel drops irq_req right after the
    // write edge and the FSM never latches a channel that is being disabled.
    assign mask_next = mask_we ? mask_wdata : mask;

    assign set_vec = (irq_in & ~irq_prev & EDGE_MASK)
                   | (irq_in & ~EDGE_MASK)
                   | N_CH'(tick);

    assign cand    = prio_enc(MAX_CH'(pending & mask_next));
    assign isv     = prio_enc(MAX_CH'(in_service));
    assign cand_oh = N_CH'(1) << cand.idx;

    // Strict nesting: only a channel more urgent than every active handler.
    assign accept  = cand.valid && (!isv.valid || (cand.idx < isv.idx));

    assign vec_calc = VEC_BASE + ADDR_W'(32'(cand.idx) * 32'(VEC_STRIDE));

    assign ack_take = (state == ST_REQ) && ack;
    assign withdraw = (state == ST_REQ) && ((cur_oh & pending & mask_next) == '0);

    // done retires the innermost (lowest-index) handler before ack adds the
    // new one, so a simultaneous pair swaps one level for another.
    assign done_clr = (done && isv.valid) ? (N_CH'(1) << isv.idx) : '0;
    assign ack_set  = {N_CH{ack_take}} & cur_oh;

    // A fresh set condition beats the ack clear on the same edge.
    assign pending_next    = (pending & ~ack_set) | set_vec;
    assign in_service_next = (in_service & ~done_clr) | ack_set;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask       <= '0;
            irq_prev   <= '0;
            pending    <= '0;
            in_service <= '0;
        end else begin
            if (mask_we)
                mask <= mask_wdata;
            irq_prev   <= irq_in;
            pending    <= pending_next;
            in_service <= in_service_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            irq_req  <= 1'b0;
            vec_addr <= '0;
            cur_oh   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state    <= ST_REQ;
                        irq_req  <= 1'b1;
                        vec_addr <= vec_calc;
                        cur_oh   <= cand_oh;
                    end
                end
                ST_REQ: begin
                    // The latched channel holds until ack or withdrawal,
                    // even if something more urgent shows up meanwhile.
                    if (ack_take || withdraw) begin
                        state    <= ST_IDLE;
                        irq_req  <= 1'b0;
                        vec_addr <= '0;
                        cur_oh   <= '0;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    irq_req  <= 1'b0;
                    vec_addr <= '0;
                    cur_oh   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_intr_ctrl.sv
module tb_intr_ctrl;

    localparam int N_CH    = 4;
    localparam int ADDR_W  = 10;
    localparam int TIMER_W = 16;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic [N_CH-1:0]    irq_in = '0;
    logic               mask_we = 1'b0;
    logic [N_CH-1:0]    mask_wdata = '0;
    logic               timer_we = 1'b0;
    logic [TIMER_W-1:0] timer_load = '0;
    logic               ack = 1'b0;
    logic               done = 1'b0;
    logic               irq_req;
    logic [ADDR_W-1:0]  vec_addr;
    logic [N_CH-1:0]    pending;
    logic [N_CH-1:0]    in_service;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic [ADDR_W-1:0] exp_q[$];

    intr_ctrl #(
        .N_CH      (N_CH),
        .ADDR_W    (ADDR_W),
        .EDGE_MASK (4'b0111),
        .TIMER_W   (TIMER_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_in),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .timer_we   (timer_we),
        .timer_load (timer_load),
        .ack        (ack),
        .done       (done),
        .irq_req    (irq_req),
        .vec_addr   (vec_addr),
        .pending    (pending),
        .in_service (in_service)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_mask(input logic [N_CH-1:0] m);
        mask_we = 1'b1;
        mask_wdata = m;
        step();
        mask_we = 1'b0;
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        step();
        ack = 1'b0;
    endtask

    task automatic pulse_done();
        done = 1'b1;
        step();
        done = 1'b0;
    endtask

    // Wait (bounded) for a request, then pop and compare its vector.
    task automatic wait_req(input string tag, input int budget);
        int n = 0;
        while (irq_req !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk({tag, " irq_req"}, 32'(irq_req), 32'd1);
        chk({tag, " scoreboard"}, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            logic [ADDR_W-1:0] e;
            e = exp_q.pop_front();
            chk({tag, " vec_addr"}, 32'(vec_addr), 32'(e));
        end
    endtask

    task automatic hold_idle(input string tag, input int n);
        logic seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            step();
            if (irq_req !== 1'b0) seen = 1'b1;
        end
        chk({tag, " no request"}, 32'(seen), 32'd0);
    endtask

    initial begin
        int t_req[3];

        // Reset state
        step();
        step();
        chk("rst irq_req", 32'(irq_req), 0);
        chk("rst vec_addr", 32'(vec_addr), 0);
        chk("rst pending", 32'(pending), 0);
        chk("rst in_service", 32'(in_service), 0);
        reset = 1'b1;
        step();

        // Single edge request, two-cycle latency, ack moves it to service
        write_mask(4'b0110);
        irq_in = 4'b0100;
        step();
        chk("t1 pending", 32'(pending), 32'h4);
        chk("t1 irq_req early", 32'(irq_req), 0);
        exp_q.push_back(10'h3C8);
        step();
        wait_req("t1", 0);
        pulse_ack();
        chk("t1 in_service", 32'(in_service), 32'h4);
        chk("t1 pending clr", 32'(pending), 0);
        chk("t1 irq_req drop", 32'(irq_req), 0);

        // Nesting: ch1 preempts ch2 service, ch3 waits for both dones
        write_mask(4'b1110);
        irq_in = 4'b0110;
        step();
        chk("t2 pending ch1", 32'(pending), 32'h2);
        exp_q.push_back(10'h3C4);
        wait_req("t2 nest", 2);
        pulse_ack();
        chk("t2 in_service", 32'(in_service), 32'h6);
        irq_in = 4'b1110;
        step();
        irq_in = 4'b0110;
        chk("t2 pending ch3", 32'(pending), 32'h8);
        hold_idle("t2 blocked2", 4);
        pulse_done();
        chk("t2 done1", 32'(in_service), 32'h4);
        hold_idle("t2 blocked1", 3);
        exp_q.push_back(10'h3CC);
        pulse_done();
        chk("t2 done2", 32'(in_service), 0);
        wait_req("t2 ch3", 3);
        pulse_ack();
        pulse_done();
        irq_in = '0;
        step();

        // Masking the latched channel withdraws the request
        irq_in = 4'b0010;
        step();
        exp_q.push_back(10'h3C4);
        wait_req("t3", 2);
        write_mask(4'b0000);
        chk("t3 withdraw", 32'(irq_req), 0);
        chk("t3 pending kept", 32'(pending[1]), 1);
        step();
        chk("t3 still idle", 32'(irq_req), 0);
        exp_q.push_back(10'h3C4);
        write_mask(4'b1110);
        wait_req("t3 resume", 2);
        pulse_ack();
        pulse_done();
        irq_in = '0;

        // ack outside REQ is ignored
        pulse_ack();
        chk("ack idle in_service", 32'(in_service), 0);

        // Timer: period of 5, then disabled
        write_mask(4'b0001);
        timer_we = 1'b1;
        timer_load = 16'd5;
        step();
        timer_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(10'h3C0);
            wait_req("t4 tick", 8);
            t_req[i] = cyc;
            pulse_ack();
            pulse_done();
        end
        chk("t4 period a", 32'(t_req[1] - t_req[0]), 5);
        chk("t4 period b", 32'(t_req[2] - t_req[1]), 5);
        timer_we = 1'b1;
        timer_load = '0;
        step();
        timer_we = 1'b0;
        hold_idle("t4 off", 12);
        chk("t4 pending", 32'(pending), 0);

        // Level ch3 held through ack keeps pending; next request after done
        write_mask(4'b1000);
        irq_in = 4'b1000;
        step();
        exp_q.push_back(10'h3CC);
        wait_req("t5", 2);
        pulse_ack();
        chk("t5 pending kept", 32'(pending), 32'h8);
        chk("t5 in_service", 32'(in_service), 32'h8);
        hold_idle("t5 blocked", 3);
        exp_q.push_back(10'h3CC);
        pulse_done();
        wait_req("t5 again", 2);
        irq_in = '0;
        pulse_ack();
        pulse_done();
        chk("t5 pending clr", 32'(pending), 0);

        // Simultaneous ack and done: done retires ch2, ack enters ch1
        write_mask(4'b0110);
        irq_in = 4'b0100;
        step();
        exp_q.push_back(10'h3C8);
        wait_req("t6 ch2", 2);
        pulse_ack();
        irq_in = 4'b0110;
        step();
        exp_q.push_back(10'h3C4);
        wait_req("t6 ch1", 2);
        ack = 1'b1;
        done = 1'b1;
        step();
        ack = 1'b0;
        done = 1'b0;
        chk("t6 ack+done", 32'(in_service), 32'h2);
        pulse_done();
        irq_in = '0;
        step();

        // Reset mid-request discards everything
        write_mask(4'b1010);
        irq_in = 4'b1010;
        step();
        irq_in = '0;
        chk("t7 pending", 32'(pending), 32'hA);
        step();
        chk("t7 in REQ", 32'(irq_req), 1);
        reset = 1'b0;
        #1;
        chk("t7 rst irq_req", 32'(irq_req), 0);
        chk("t7 rst vec_addr", 32'(vec_addr), 0);
        chk("t7 rst pending", 32'(pending), 0);
        step();
        step();
        reset = 1'b1;
        hold_idle("t7 after release", 6);
        chk("t7 pending after", 32'(pending), 0);
        chk("t7 in_service after", 32'(in_service), 0);
        chk("t7 vec_addr after", 32'(vec_addr), 0);
        chk("scoreboard drained", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
